// File: rtl/spiker_writer_if.sv
// Spike event stream, frame control and result read port of spiker_writer.
// The slave modport is the writer's side; the master modport is the driver's side.
interface spiker_writer_if #(
  parameter int WIDTH    = 32,
  parameter int N_SPIKES = 784
);
  localparam int N_WORDS = (N_SPIKES + WIDTH - 1) / WIDTH;
  localparam int IDX_W   = $clog2(N_SPIKES);
  localparam int ADDR_W  = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

  logic              start_i;
  logic              spike_valid_i;
  logic [IDX_W-1:0]  spike_idx_i;
  logic              spike_last_i;
  logic              spike_ready_o;
  logic              busy_o;
  logic              done_o;
  logic              err_o;
  logic [ADDR_W-1:0] rd_addr_i;
  logic [WIDTH-1:0]  rd_data_o;
  logic [IDX_W:0]    spike_cnt_o;

  modport slave (
    input  start_i, spike_valid_i, spike_idx_i, spike_last_i, rd_addr_i,
    output spike_ready_o, busy_o, done_o, err_o, rd_data_o, spike_cnt_o
  );

  modport master (
    output start_i, spike_valid_i, spike_idx_i, spike_last_i, rd_addr_i,
    input  spike_ready_o, busy_o, done_o, err_o, rd_data_o, spike_cnt_o
  );
endinterface

// File: rtl/spiker_writer.sv
// spiker_writer: packs a stream of spike indices into a word-addressed bit buffer.
// Define SPIKER_WRITER_CNT_EN to build the saturating accepted-spike counter.
module spiker_writer #(
  parameter int WIDTH    = 32,
  parameter int N_SPIKES = 784
) (
  input logic            clk_i,
  input logic            rst_ni,
  spiker_writer_if.slave bus
);
  localparam int N_WORDS = (N_SPIKES + WIDTH - 1) / WIDTH;
  localparam int IDX_W   = $clog2(N_SPIKES);
  localparam int ADDR_W  = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam int BIT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [ADDR_W-1:0] LAST_WORD   = ADDR_W'(N_WORDS - 1);
  localparam logic [ADDR_W:0]   WORD_LIMIT  = (ADDR_W + 1)'(N_WORDS);
  localparam logic [IDX_W:0]    SPIKE_LIMIT = (IDX_W + 1)'(N_SPIKES);

  typedef enum logic [1:0] {IDLE, CLEAR, COLLECT, DONE} state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] wcnt;
  logic [WIDTH-1:0]  words [N_WORDS];
  logic [WIDTH-1:0]  rd_data;
  logic              err;
  logic              ready;
  logic              busy;
  logic              done;
  logic              handshake;
  logic              idx_ok;
  logic              restart;
  logic [ADDR_W-1:0] word_sel;
  logic [BIT_W-1:0]  bit_sel;

  assign handshake = bus.spike_valid_i && ready;
  assign idx_ok    = {1'b0, bus.spike_idx_i} < SPIKE_LIMIT;
  assign restart   = bus.start_i && ((state == IDLE) || (state == DONE));
  assign word_sel  = ADDR_W'(32'(bus.spike_idx_i) / WIDTH);
  assign bit_sel   = BIT_W'(32'(bus.spike_idx_i) % WIDTH);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start_i) state_next = CLEAR;
      CLEAR:   if (wcnt == LAST_WORD) state_next = COLLECT;
      COLLECT: if (handshake && bus.spike_last_i) state_next = DONE;
      DONE:    if (bus.start_i) state_next = CLEAR;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are pure decodes of the state flops, so ready never follows valid.
  always_comb begin
    ready = (state == COLLECT);
    busy  = (state == CLEAR) || (state == COLLECT);
    done  = (state == DONE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)              wcnt <= '0;
    else if (restart)         wcnt <= '0;
    else if (state == CLEAR)  wcnt <= wcnt + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                  err <= 1'b0;
    else if (restart)             err <= 1'b0;
    else if (handshake && !idx_ok) err <= 1'b1;
  end

  // Only in-range indices are ever written, so padding bits of the last word stay 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N_WORDS; i++) words[i] <= '0;
    end else if (state == CLEAR) begin
      words[wcnt] <= '0;
    end else if (handshake && idx_ok) begin
      words[word_sel][bit_sel] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                 rd_data <= '0;
    else if ({1'b0, bus.rd_addr_i} < WORD_LIMIT) rd_data <= words[bus.rd_addr_i];
    else                                         rd_data <= '0;
  end

`ifdef SPIKER_WRITER_CNT_EN
  logic [IDX_W:0] cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                    cnt <= '0;
    else if (restart)                               cnt <= '0;
    else if (handshake && idx_ok && (cnt != '1))    cnt <= cnt + 1'b1;
  end

  assign bus.spike_cnt_o = cnt;
`else
  assign bus.spike_cnt_o = '0;
`endif

  assign bus.spike_ready_o = ready;
  assign bus.busy_o        = busy;
  assign bus.done_o        = done;
  assign bus.err_o         = err;
  assign bus.rd_data_o     = rd_data;
endmodule

// File: tb/tb_spiker_writer.sv
// Directed testbench for spiker_writer (784 spikes, 32-bit words, 25 result words).
// Expected counts follow SPIKER_WRITER_CNT_EN so the bench matches either build.
module tb_spiker_writer;
  localparam int WIDTH    = 32;
  localparam int N_SPIKES = 784;
  localparam int N_WORDS  = 25;
  localparam int IDX_W    = 10;
  localparam int ADDR_W   = 5;
`ifdef SPIKER_WRITER_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  int   tests_run    = 0;
  int   tests_failed = 0;

  spiker_writer_if #(.WIDTH(WIDTH), .N_SPIKES(N_SPIKES)) bus ();

  spiker_writer #(.WIDTH(WIDTH), .N_SPIKES(N_SPIKES)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [IDX_W:0] exp_cnt(input int n);
    return CNT_EN ? (IDX_W + 1)'(n) : '0;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic pulse_start();
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
  endtask

  task automatic read_word(input int addr, output logic [WIDTH-1:0] data);
    bus.rd_addr_i = ADDR_W'(addr);
    tick();
    data = bus.rd_data_o;
  endtask

  // Counts cycles (including the one already elapsed) until ready rises.
  task automatic wait_ready(input int already, output int cycles);
    cycles = already;
    while (!bus.spike_ready_o && cycles < 200) begin
      tick();
      cycles++;
    end
    if (!bus.spike_ready_o) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL wait_ready timeout: ready=%b required 1", bus.spike_ready_o);
    end
  endtask

  task automatic send_spike(input int idx, input bit last);
    int waited = 0;
    bus.spike_valid_i = 1'b1;
    bus.spike_idx_i   = IDX_W'(idx);
    bus.spike_last_i  = last;
    while (!bus.spike_ready_o && waited < 200) begin
      tick();
      waited++;
    end
    if (!bus.spike_ready_o) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL send_spike timeout idx=%0d: ready=%b required 1", idx, bus.spike_ready_o);
    end else begin
      tick();
    end
    bus.spike_valid_i = 1'b0;
    bus.spike_last_i  = 1'b0;
  endtask

  task automatic test_reset();
    logic [WIDTH-1:0] data;
    int cycles;
    int nonzero;
    rst_ni = 1'b0;
    #12;
    tests_run++;
    if ({bus.spike_ready_o, bus.busy_o, bus.done_o, bus.err_o} !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL reset_flags: got %b required 0000",
               {bus.spike_ready_o, bus.busy_o, bus.done_o, bus.err_o});
    end
    tests_run++;
    if (bus.rd_data_o !== '0 || bus.spike_cnt_o !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_data: rd_data=%h cnt=%0d required 0 0", bus.rd_data_o, bus.spike_cnt_o);
    end
    rst_ni = 1'b1;
    tick();
    pulse_start();
    tests_run++;
    if (bus.busy_o !== 1'b1 || bus.spike_ready_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL clear_state: busy=%b ready=%b required 1 0", bus.busy_o, bus.spike_ready_o);
    end
    wait_ready(1, cycles);
    tests_run++;
    if (cycles !== 26) begin
      tests_failed++;
      $display("[TB] FAIL start_to_ready: got %0d cycles required 26", cycles);
    end
    nonzero = 0;
    for (int a = 0; a < N_WORDS; a++) begin
      read_word(a, data);
      if (data !== '0) nonzero++;
    end
    tests_run++;
    if (nonzero !== 0) begin
      tests_failed++;
      $display("[TB] FAIL reset_buffer_zero: %0d nonzero words required 0", nonzero);
    end
  endtask

  task automatic test_basic_frame();
    logic [WIDTH-1:0] data;
    send_spike(0, 1'b0);
    send_spike(31, 1'b0);
    send_spike(32, 1'b0);
    send_spike(783, 1'b1);
    tests_run++;
    if (bus.done_o !== 1'b1 || bus.busy_o !== 1'b0 || bus.spike_ready_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL basic_done: done=%b busy=%b ready=%b required 1 0 0",
               bus.done_o, bus.busy_o, bus.spike_ready_o);
    end
    read_word(0, data);
    tests_run++;
    if (data !== 32'h8000_0001) begin
      tests_failed++;
      $display("[TB] FAIL basic_word0: got %h required 80000001", data);
    end
    read_word(1, data);
    tests_run++;
    if (data !== 32'h0000_0001) begin
      tests_failed++;
      $display("[TB] FAIL basic_word1: got %h required 00000001", data);
    end
    read_word(24, data);
    tests_run++;
    if (data !== 32'h0000_8000) begin
      tests_failed++;
      $display("[TB] FAIL basic_word24: got %h required 00008000", data);
    end
    read_word(25, data);
    tests_run++;
    if (data !== '0) begin
      tests_failed++;
      $display("[TB] FAIL read_out_of_range: got %h required 0", data);
    end
    tests_run++;
    if (bus.spike_cnt_o !== exp_cnt(4) || bus.err_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL basic_count: cnt=%0d err=%b required %0d 0", bus.spike_cnt_o, bus.err_o, exp_cnt(4));
    end
  endtask

  task automatic test_duplicate_oor();
    logic [WIDTH-1:0] data;
    int cycles;
    pulse_start();
    wait_ready(1, cycles);
    send_spike(5, 1'b0);
    send_spike(5, 1'b0);
    send_spike(800, 1'b0);
    send_spike(6, 1'b1);
    read_word(0, data);
    tests_run++;
    if (data !== 32'h0000_0060) begin
      tests_failed++;
      $display("[TB] FAIL dup_word0: got %h required 00000060", data);
    end
    read_word(24, data);
    tests_run++;
    if (data !== '0) begin
      tests_failed++;
      $display("[TB] FAIL dup_word24_cleared: got %h required 0", data);
    end
    tests_run++;
    if (bus.err_o !== 1'b1 || bus.spike_cnt_o !== exp_cnt(3)) begin
      tests_failed++;
      $display("[TB] FAIL dup_err_count: err=%b cnt=%0d required 1 %0d", bus.err_o, bus.spike_cnt_o, exp_cnt(3));
    end
  endtask

  task automatic test_restart();
    logic [WIDTH-1:0] data;
    int cycles;
    int nonzero;
    pulse_start();
    tests_run++;
    if (bus.done_o !== 1'b0 || bus.err_o !== 1'b0 || bus.spike_cnt_o !== '0) begin
      tests_failed++;
      $display("[TB] FAIL restart_clear: done=%b err=%b cnt=%0d required 0 0 0",
               bus.done_o, bus.err_o, bus.spike_cnt_o);
    end
    wait_ready(1, cycles);
    tests_run++;
    if (cycles !== 26) begin
      tests_failed++;
      $display("[TB] FAIL restart_to_ready: got %0d cycles required 26", cycles);
    end
    nonzero = 0;
    for (int a = 0; a < N_WORDS; a++) begin
      read_word(a, data);
      if (data !== '0) nonzero++;
    end
    tests_run++;
    if (nonzero !== 0) begin
      tests_failed++;
      $display("[TB] FAIL restart_buffer_zero: %0d nonzero words required 0", nonzero);
    end
    send_spike(10, 1'b1);
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] data;
    int cycles;
    int ready_in_clear;
    bus.spike_valid_i = 1'b1;
    bus.spike_idx_i   = IDX_W'(0);
    bus.spike_last_i  = 1'b0;
    pulse_start();
    ready_in_clear = 0;
    cycles = 1;
    while (!bus.spike_ready_o && cycles < 200) begin
      tick();
      cycles++;
    end
    bus.spike_valid_i = 1'b0;
    tests_run++;
    if (cycles !== 26) begin
      tests_failed++;
      $display("[TB] FAIL backpressure_ready: ready after %0d cycles required 26", cycles);
    end
    tests_run++;
    if (bus.spike_cnt_o !== '0) begin
      tests_failed++;
      $display("[TB] FAIL backpressure_count: got %0d required 0", bus.spike_cnt_o);
    end
    send_spike(3, 1'b0);
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    tick();
    tests_run++;
    if (bus.spike_ready_o !== 1'b1 || bus.busy_o !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL ignored_start: ready=%b busy=%b required 1 1", bus.spike_ready_o, bus.busy_o);
    end
    send_spike(4, 1'b1);
    read_word(0, data);
    tests_run++;
    if (data !== 32'h0000_0018) begin
      tests_failed++;
      $display("[TB] FAIL backpressure_word0: got %h required 00000018", data);
    end
    tests_run++;
    if (bus.spike_cnt_o !== exp_cnt(2) || bus.done_o !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL backpressure_done: cnt=%0d done=%b required %0d 1", bus.spike_cnt_o, bus.done_o, exp_cnt(2));
    end
    if (ready_in_clear != 0) $display("[TB] note: unexpected ready count %0d", ready_in_clear);
  endtask

  task automatic test_read_latency();
    int cycles;
    pulse_start();
    wait_ready(1, cycles);
    bus.rd_addr_i     = ADDR_W'(3);
    bus.spike_valid_i = 1'b1;
    bus.spike_idx_i   = IDX_W'(96);
    bus.spike_last_i  = 1'b1;
    tick();
    bus.spike_valid_i = 1'b0;
    bus.spike_last_i  = 1'b0;
    tests_run++;
    if (bus.rd_data_o !== '0 || bus.done_o !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL latency_prewrite: rd_data=%h done=%b required 0 1", bus.rd_data_o, bus.done_o);
    end
    tick();
    tests_run++;
    if (bus.rd_data_o !== 32'h0000_0001) begin
      tests_failed++;
      $display("[TB] FAIL latency_postwrite: got %h required 00000001", bus.rd_data_o);
    end
  endtask

  task automatic test_reset_mid();
    logic [WIDTH-1:0] data;
    int cycles;
    pulse_start();
    wait_ready(1, cycles);
    send_spike(900, 1'b0);
    send_spike(7, 1'b0);
    bus.rd_addr_i = ADDR_W'(0);
    tick();
    tests_run++;
    if (bus.err_o !== 1'b1 || bus.rd_data_o !== 32'h0000_0080) begin
      tests_failed++;
      $display("[TB] FAIL premid_state: err=%b word0=%h required 1 00000080", bus.err_o, bus.rd_data_o);
    end
    #1;
    rst_ni = 1'b0;
    #1;
    tests_run++;
    if ({bus.spike_ready_o, bus.busy_o, bus.done_o, bus.err_o} !== 4'b0000 ||
        bus.rd_data_o !== '0 || bus.spike_cnt_o !== '0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_outputs: flags=%b rd_data=%h cnt=%0d required 0000 0 0",
               {bus.spike_ready_o, bus.busy_o, bus.done_o, bus.err_o}, bus.rd_data_o, bus.spike_cnt_o);
    end
    #1;
    rst_ni = 1'b1;
    read_word(0, data);
    tick();
    tests_run++;
    if (data !== '0 || bus.spike_ready_o !== 1'b0 || bus.busy_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_idle: word0=%h ready=%b busy=%b required 0 0 0",
               data, bus.spike_ready_o, bus.busy_o);
    end
  endtask

  initial begin
    bus.start_i       = 1'b0;
    bus.spike_valid_i = 1'b0;
    bus.spike_idx_i   = '0;
    bus.spike_last_i  = 1'b0;
    bus.rd_addr_i     = '0;
    test_reset();
    test_basic_frame();
    test_duplicate_oor();
    test_restart();
    test_backpressure();
    test_read_latency();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/spiker_writer.md
# spiker_writer

Collects spike events from the SNN core, one spike index per handshake, and packs them into an N_SPIKES-bit result buffer organised as WIDTH-bit words. Register-file glue reads the buffer word by word into the spikes_result registers. It is the write-side counterpart of the spike-vector reader: the reader unpacks register words into a flat spike vector, and this block rebuilds a packed vector from a spike event stream. It sits between the core's spike output port and the adapter's hw2reg result path.

## Interface
Parameters:
- WIDTH, 32, bits per result word
- N_SPIKES, 784, number of spike bits in the buffer
- Derived values:
  - N_WORDS = (N_SPIKES+WIDTH-1)/WIDTH
  - IDX_W = $clog2(N_SPIKES)
  - ADDR_W = max(1, $clog2(N_WORDS))

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- start_i  in  1  single-cycle pulse that begins a new frame
- spike_valid_i  in  1  spike event valid
- spike_idx_i  in  IDX_W  spike index
- spike_last_i  in  1  marks the last event of the frame; qualified by the handshake
- spike_ready_o  out  1  block accepts an event
- busy_o  out  1  high in CLEAR or COLLECT
- done_o  out  1  high in DONE
- err_o  out  1  sticky flag: an out-of-range index was received this frame
- rd_addr_i  in  ADDR_W  read word address
- rd_data_o  out  WIDTH  registered read data
- spike_cnt_o  out  IDX_W+1  accepted-spike count (see Configuration)

## Operation
- FSM states: IDLE, CLEAR, COLLECT, DONE. Reset state is IDLE.
- IDLE:
  - spike_ready_o=0.
  - start_i=1 moves to CLEAR, sets the word counter to 0, clears err_o, clears the count.
- CLEAR:
  - Zeroes word[wcnt] each cycle and increments wcnt.
  - After word N_WORDS-1 is zeroed, moves to COLLECT.
  - start_i is ignored. spike_ready_o=0.
- COLLECT:
  - spike_ready_o=1.
  - Handshake is spike_valid_i && spike_ready_o.
  - On a handshake with idx < N_SPIKES: bit idx is set (OR). Duplicate indices are idempotent. The count increments.
  - On a handshake with idx >= N_SPIKES: no bit is written, err_o is set, and the count is unchanged.
  - A handshake with spike_last_i=1 applies the event, then moves to DONE.
  - start_i is ignored in COLLECT.
- DONE:
  - done_o=1, spike_ready_o=0.
  - Buffer and count are held.
  - start_i=1 moves to CLEAR; done_o falls on the next cycle.
- Read path:
  - rd_data_o <= word[rd_addr_i] on every cycle, in every state.
  - rd_addr_i >= N_WORDS returns 0.
  - Bits at positions >= N_SPIKES in the last word always read 0.
- The count saturates at 2^(IDX_W+1)-1.

## Timing
- Reset values: spike_ready_o=0, busy_o=0, done_o=0, err_o=0, rd_data_o=0, spike_cnt_o=0, all buffer bits 0.
- start_i to first ready cycle: start at cycle t, CLEAR during cycles t+1..t+N_WORDS, spike_ready_o=1 at cycle t+N_WORDS+1.
- Handshake at cycle t: the bit is visible at rd_data_o in cycle t+2 (one cycle to write, one cycle of read latency). A read of the same word in cycle t returns the pre-write value.
- Last handshake at t: done_o=1 at t+1.
- Reset asserted mid-operation: returns to IDLE immediately and all state is cleared. No partial frame survives.
- spike_ready_o is a registered state decode and does not depend combinationally on spike_valid_i.

## Configuration
- SPIKER_WRITER_CNT_EN defined: the saturating accepted-spike counter is built, and spike_cnt_o reports it.
- SPIKER_WRITER_CNT_EN undefined: no counter flops are built, and spike_cnt_o is tied to 0.
- The port list is identical in both builds.

## Test plan
- Reset sequence:
  - Stimulus: reset, then start_i with N_SPIKES=784, WIDTH=32.
  - Required: ready rises exactly 26 cycles after start (25 CLEAR cycles); every word reads 0.
- Basic frame:
  - Stimulus: idx 0, 31, 32, 783 (last).
  - Required: word0=0x80000001, word1=0x00000001, word24=0x00008000; done_o=1; count=4 when SPIKER_WRITER_CNT_EN is defined, else 0.
- Duplicate and out-of-range:
  - Stimulus: idx 5 twice, then idx 800, then idx 6 (last).
  - Required: word0=0x00000060, err_o=1, count=3.
- Backpressure and ignored start:
  - Stimulus: hold spike_valid_i during CLEAR; pulse start_i during COLLECT.
  - Required: no write during CLEAR; the frame is not restarted.
- Restart and reset:
  - Stimulus: start_i in DONE.
  - Required: all words cleared, err_o=0, count=0.
  - Stimulus: rst_ni pulsed mid-COLLECT.
  - Required: IDLE, all outputs at reset values.
